// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern generator: mode encodings and widths.
package led_pattern_pkg;

   localparam int MODE_W  = 2;
   localparam int FRAME_W = 16;

   typedef enum logic [MODE_W-1:0] {
      LED_OFF     = 2'd0,
      LED_ON      = 2'd1,
      LED_BLINK   = 2'd2,
      LED_BREATHE = 2'd3
   } led_mode_t;

   // Rate exponents above 15 would index past the frame counter.
   function automatic logic [3:0] sat_rate(input logic [31:0] r);
      return (r > 32'd15) ? 4'd15 : r[3:0];
   endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow/active config, blink/breathe state, PWM compare.
// LED_GAMMA_EN adds a squared-duty perceptual correction after the mode logic.
module led_pwm_channel
   import led_pattern_pkg::*;
#(
   parameter int PW         = 8,
   parameter int RATE_W     = 4,
   parameter int ACTIVE_LOW = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  led_mode_t          mode,
   input  logic [PW-1:0]      duty,
   input  logic [RATE_W-1:0]  rate,
   input  logic               load,
   input  logic [PW-1:0]      pwm_cnt,
   input  logic [FRAME_W-1:0] frame_cnt,
   output logic               led
);

   localparam logic [PW-1:0] MAX = '1;
   localparam logic POL = (ACTIVE_LOW != 0);

   led_mode_t          sh_mode, act_mode;
   logic [PW-1:0]      sh_duty, act_duty, level;
   logic [RATE_W-1:0]  sh_rate, act_rate;
   logic               dir_dn;
   logic [3:0]         rate_s;
   logic [FRAME_W-1:0] fc_next, step_mask;
   logic               step;
   logic [2*PW-1:0]    scaled, sq;
   logic [PW-1:0]      mode_duty, eff_duty;
   logic               lit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_mode <= LED_OFF;
         sh_duty <= '0;
         sh_rate <= '0;
      end else if (we) begin
         sh_mode <= mode;
         sh_duty <= duty;
         sh_rate <= rate;
      end
   end

   // Active config and breathe state only move at frame boundaries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_mode <= LED_OFF;
         act_duty <= '0;
         act_rate <= '0;
         level    <= '0;
         dir_dn   <= 1'b0;
      end else if (load) begin
         act_mode <= sh_mode;
         act_duty <= sh_duty;
         act_rate <= sh_rate;
         if (sh_mode != act_mode) begin
            level  <= '0;
            dir_dn <= 1'b0;
         end else if (sh_mode == LED_BREATHE && step) begin
            if (!dir_dn) begin
               if (level == MAX) dir_dn <= 1'b1;
               else level <= level + PW'(1);
            end else begin
               if (level == '0) dir_dn <= 1'b0;
               else level <= level - PW'(1);
            end
         end
      end
   end

   always_comb begin
      rate_s    = sat_rate(32'(act_rate));
      fc_next   = frame_cnt + FRAME_W'(1);
      step_mask = (FRAME_W'(1) << rate_s) - FRAME_W'(1);
      step      = (fc_next & step_mask) == '0;
      scaled    = (2*PW)'(level) * (2*PW)'(act_duty);
      mode_duty = '0;
      unique case (act_mode)
         LED_ON:      mode_duty = act_duty;
         LED_BLINK:   mode_duty = frame_cnt[rate_s] ? act_duty : '0;
         LED_BREATHE: mode_duty = (level == MAX) ? act_duty
                                                 : scaled[2*PW-1:PW];
         default:     mode_duty = '0;
      endcase
`ifdef LED_GAMMA_EN
      sq       = (2*PW)'(mode_duty) * (2*PW)'(mode_duty);
      eff_duty = (mode_duty == MAX) ? MAX : sq[2*PW-1:PW];
`else
      sq       = '0;
      eff_duty = mode_duty;
`endif
      lit = (pwm_cnt < eff_duty) || (eff_duty == MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) led <= POL;
      else     led <= lit ^ POL;
   end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern driver: shared prescaled PWM timebase and config fan-out.
// Build with LED_GAMMA_EN defined for perceptual (squared) duty correction.
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int NCH        = 3,
   parameter int PW         = 8,
   parameter int PRESCALE   = 47,
   parameter int RATE_W     = 4,
   parameter int ACTIVE_LOW = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [2:0]        cfg_ch,
   input  logic [MODE_W-1:0] cfg_mode,
   input  logic [PW-1:0]     cfg_duty,
   input  logic [RATE_W-1:0] cfg_rate,
   output logic [NCH-1:0]    led_out,
   output logic              frame_sync
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0]    ps;
   logic [PW-1:0]      pwm_cnt;
   logic [FRAME_W-1:0] frame_cnt;
   logic               tick, frame_start;

   assign tick        = (ps == PS_W'(PRESCALE - 1));
   assign frame_start = tick && (pwm_cnt == '1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ps         <= '0;
         pwm_cnt    <= '0;
         frame_cnt  <= '0;
         frame_sync <= 1'b0;
      end else begin
         ps         <= tick ? '0 : ps + PS_W'(1);
         pwm_cnt    <= pwm_cnt + PW'(tick);
         frame_cnt  <= frame_cnt + FRAME_W'(frame_start);
         frame_sync <= frame_start;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      led_pwm_channel #(
         .PW         (PW),
         .RATE_W     (RATE_W),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .we        (cfg_we && (cfg_ch == 3'(i))),
         .mode      (led_mode_t'(cfg_mode)),
         .duty      (cfg_duty),
         .rate      (cfg_rate),
         .load      (frame_start),
         .pwm_cnt   (pwm_cnt),
         .frame_cnt (frame_cnt),
         .led       (led_out[i])
      );
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: per-frame lit-cycle counts per channel.
// Extra instances cover ACTIVE_LOW=1 and PRESCALE=3 timing.
module tb_led_pattern_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_we = 1'b0;
   logic [2:0] cfg_ch = '0;
   logic [1:0] cfg_mode = '0;
   logic [7:0] cfg_duty = '0;
   logic [3:0] cfg_rate = '0;
   logic [2:0] led_out, led2, led3;
   logic       frame_sync, fs2, fs3;

   int tests = 0;
   int fails = 0;
   int frames = 0;
   int cur = 0;

   typedef struct {
      int frame;
      int ch;
      int cnt;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   led_pattern_gen #(.NCH(3), .PW(8), .PRESCALE(1), .RATE_W(4), .ACTIVE_LOW(0)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
      .cfg_duty(cfg_duty), .cfg_rate(cfg_rate), .led_out(led_out), .frame_sync(frame_sync));

   led_pattern_gen #(.NCH(3), .PW(8), .PRESCALE(1), .RATE_W(4), .ACTIVE_LOW(1)) dut_al (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
      .cfg_duty(cfg_duty), .cfg_rate(cfg_rate), .led_out(led2), .frame_sync(fs2));

   led_pattern_gen #(.NCH(3), .PW(8), .PRESCALE(3), .RATE_W(4), .ACTIVE_LOW(0)) dut_ps (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
      .cfg_duty(cfg_duty), .cfg_rate(cfg_rate), .led_out(led3), .frame_sync(fs3));

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Lit cycles per 256-cycle frame for a final duty value.
   function automatic int lc(input int d);
      int r;
      r = d;
`ifdef LED_GAMMA_EN
      if (r != 255) r = (r * r) >> 8;
`endif
      return (r == 255) ? 256 : r;
   endfunction

   task automatic push3(input int f, input int a, input int b, input int c);
      q.push_back('{f, 0, a});
      q.push_back('{f, 1, b});
      q.push_back('{f, 2, c});
   endtask

   task automatic wr(input int ch, input int mode, input int duty, input int rate);
      cfg_ch   = 3'(ch);
      cfg_mode = 2'(mode);
      cfg_duty = 8'(duty);
      cfg_rate = 4'(rate);
      cfg_we   = 1'b1;
      @(posedge clk);
      #1 cfg_we = 1'b0;
   endtask

   task automatic sync();
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (frame_sync) begin
            cur++;
            return;
         end
      end
      check("frame_sync timeout", 0, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   endtask

   // Monitor: accumulate lit cycles, compare against scoreboard on frame close.
   initial begin
      int   cnt[3];
      int   cnt2[3];
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            frames = 0;
            for (int c = 0; c < 3; c++) begin
               cnt[c]  = 0;
               cnt2[c] = 0;
            end
         end else begin
            for (int c = 0; c < 3; c++) begin
               cnt[c]  += int'(led_out[c]);
               cnt2[c] += int'(!led2[c]);
            end
            if (frame_sync) begin
               while (q.size() > 0 && q[0].frame <= frames) begin
                  e = q.pop_front();
                  if (e.frame < frames)
                     check($sformatf("missed f%0d", e.frame), frames, e.frame);
                  else begin
                     check($sformatf("f%0d ch%0d lit", e.frame, e.ch), cnt[e.ch], e.cnt);
                     check($sformatf("f%0d ch%0d lit_al", e.frame, e.ch), cnt2[e.ch], e.cnt);
                  end
               end
               for (int c = 0; c < 3; c++) begin
                  cnt[c]  = 0;
                  cnt2[c] = 0;
               end
               frames++;
            end
         end
      end
   end

   initial begin
      int first, first3, lvl, d;
      first  = -1;
      first3 = -1;
      for (int f = 0; f < 4; f++) push3(f, 0, 0, 0);
      repeat (4) @(negedge clk);
      check("rst led_out", int'(led_out), 0);
      check("rst led_al", int'(led2), 7);
      check("rst frame_sync", int'(frame_sync), 0);
      rst = 1'b0;
      @(negedge clk);
      check("post-rst led_out", int'(led_out), 0);
      check("post-rst frame_sync", int'(frame_sync), 0);
      for (int i = 2; i <= 800; i++) begin
         @(negedge clk);
         if (frame_sync) begin
            cur++;
            if (first < 0) first = i;
         end
         if (fs3 && first3 < 0) first3 = i;
      end
      check("first sync cycles", first, 256);
      check("first sync ps3", first3, 768);
      check("syncs in 800", cur, 3);

      // ON duty 64 / 0 / 255
      wr(0, 1, 64, 0);
      wr(1, 1, 0, 0);
      wr(2, 1, 255, 0);
      push3(cur + 1, lc(64), lc(0), lc(255));

      // mid-frame write at pwm_cnt 100
      sync();
      repeat (100) @(negedge clk);
      wr(0, 1, 200, 0);
      push3(cur + 1, lc(200), lc(0), lc(255));

      // write coincident with frame_sync, last-write-wins on ch1
      sync();
      wr(0, 1, 10, 0);
      wr(1, 1, 30, 0);
      wr(1, 1, 90, 0);
      push3(cur + 1, lc(10), lc(90), lc(255));

      // out-of-range channels are ignored
      sync();
      wr(5, 1, 77, 0);
      wr(3, 0, 77, 0);
      push3(cur + 1, lc(10), lc(90), lc(255));

      // BLINK rate 0 on ch0, rate 2 on ch1
      sync();
      wr(0, 2, 255, 0);
      wr(1, 2, 255, 2);
      wr(2, 0, 200, 0);
      for (int f = cur + 1; f <= cur + 12; f++)
         push3(f, f[0] ? 256 : 0, f[2] ? 256 : 0, 0);
      while (cur < 19) sync();

      // BREATHE rate 0 on ch2, steady 128 on ch1
      wr(0, 0, 0, 0);
      wr(1, 1, 128, 0);
      wr(2, 3, 255, 0);
      for (int j = 0; j <= 257; j++) begin
         lvl = (j <= 255) ? j : 511 - j;
         d   = (lvl == 255) ? 255 : (lvl * 255) >> 8;
         push3(cur + 1 + j, 0, lc(128), lc(d));
      end
      while (cur < 278) sync();

      // pending write then reset mid-frame
      wr(1, 1, 200, 0);
      repeat (100) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid-rst led_out", int'(led_out), 0);
      check("mid-rst led_al", int'(led2), 7);
      check("mid-rst frame_sync", int'(frame_sync), 0);
      q.delete();
      repeat (3) @(negedge clk);
      push3(0, 0, 0, 0);
      push3(1, 0, 0, 0);
      cur = 0;
      rst = 1'b0;
      sync();
      sync();
      @(negedge clk);
      check("scoreboard drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
